// File: rtl/differential_decoder.sv
// Streaming differential decoder: integrates N 2-bit symbols serially, one per clock.
// Optional macro DIFF_DEC_CHAIN_EN carries the last decoded base across words.
module differential_decoder #(
  parameter int unsigned N = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic           in_first_i,
  input  logic [2*N-1:0] word_in_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [2*N-1:0] word_out_o
);

  localparam int unsigned CntW = $clog2(N) + 1;
  localparam int unsigned W    = 2 * N;

  typedef enum logic [1:0] {StIdle, StDecode, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [W-1:0]    word_q, word_d;
  logic [1:0]      carry_q, carry_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [1:0] carry_start;
  logic [1:0] sym;
  logic [1:0] sum;
  logic       accept;
  logic       last_sym;

  // Symbol 0 sits in the MSBs; the shift register moves the next symbol up each cycle.
  assign sym      = shift_q[W-1 -: 2];
  assign sum      = carry_q + sym;
  assign accept   = in_valid_i && (state_q == StIdle);
  assign last_sym = (cnt_q == CntW'(N - 1));

`ifdef DIFF_DEC_CHAIN_EN
  assign carry_start = in_first_i ? 2'b00 : carry_q;
`else
  logic unused_first;
  assign unused_first = in_first_i;
  assign carry_start  = 2'b00;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StDecode;
      StDecode: if (last_sym) state_d = StDone;
      StDone:   if (out_ready_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == StIdle) && !rst_i;
    out_valid_o = (state_q == StDone);
    word_out_o  = word_q;
  end

  // carry_q doubles as the running accumulator, so it ends each word holding d[N-1].
  always_comb begin
    shift_d = shift_q;
    word_d  = word_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (accept) begin
      shift_d = word_in_i;
      carry_d = carry_start;
      cnt_d   = '0;
    end else if (state_q == StDecode) begin
      shift_d = shift_q << 2;
      carry_d = sum;
      cnt_d   = cnt_q + 1'b1;
      for (int unsigned i = 0; i < N; i++) begin
        if (cnt_q == CntW'(i)) begin
          word_d[2*(N-1-i) +: 2] = sum;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shift_q <= '0;
      word_q  <= '0;
      carry_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      word_q  <= word_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_differential_decoder.sv
// Directed bench for differential_decoder: an N=8 instance plus an N=1 instance.
module tb_differential_decoder;
  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_first, out_valid, out_ready;
  logic [15:0]  word_in, word_out;
  logic         in_valid1, in_ready1, in_first1, out_valid1, out_ready1;
  logic [1:0]   word_in1, word_out1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  differential_decoder #(.N(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_first_i  (in_first),
    .word_in_i   (word_in),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .word_out_o  (word_out)
  );

  differential_decoder #(.N(1)) dut1 (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid1),
    .in_ready_o  (in_ready1),
    .in_first_i  (in_first1),
    .word_in_i   (word_in1),
    .out_valid_o (out_valid1),
    .out_ready_i (out_ready1),
    .word_out_o  (word_out1)
  );

  // Drive one word, wait for acceptance, return negedges from acceptance to out_valid.
  task automatic send_word(input logic [15:0] w, input logic first, output int lat);
    int wait_c = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && wait_c < 40) begin
      @(negedge clk);
      wait_c++;
    end
    in_valid = 1'b1;
    word_in  = w;
    in_first = first;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready got %b want 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || word_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b word=%h want 0/0000", out_valid, word_out);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_in_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_decode();
    int lat;
    send_word(16'b10_01_00_01_00_01_01_10, 1'b1, lat);
    checks++;
    if (lat != N) begin
      errors++;
      $display("FAIL decode_latency got %0d want %0d", lat, N);
    end
    checks++;
    if (word_out !== 16'b10_11_11_00_00_01_10_00) begin
      errors++;
      $display("FAIL decode_word got %h want %h", word_out, 16'b10_11_11_00_00_01_10_00);
    end
    take_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL handshake_return got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_wrap();
    int lat;
    send_word(16'b00_11_11_11_11_11_11_11, 1'b1, lat);
    checks++;
    if (word_out !== 16'b00_11_10_01_00_11_10_01 || lat != N) begin
      errors++;
      $display("FAIL wrap_word got %h lat %0d want %h lat %0d", word_out, lat,
               16'b00_11_10_01_00_11_10_01, N);
    end
    take_out();
  endtask

  task automatic test_chain();
    int lat;
    logic [15:0] exp_chain;
`ifdef DIFF_DEC_CHAIN_EN
    exp_chain = 16'h5555;
`else
    exp_chain = 16'h0000;
`endif
    send_word(16'h4000, 1'b1, lat);
    checks++;
    if (word_out !== 16'h5555) begin
      errors++;
      $display("FAIL chain_first got %h want 5555", word_out);
    end
    take_out();
    send_word(16'h0000, 1'b0, lat);
    checks++;
    if (word_out !== exp_chain) begin
      errors++;
      $display("FAIL chain_carry got %h want %h", word_out, exp_chain);
    end
    take_out();
    send_word(16'h0000, 1'b1, lat);
    checks++;
    if (word_out !== 16'h0000) begin
      errors++;
      $display("FAIL first_wins got %h want 0000", word_out);
    end
    take_out();
  endtask

  task automatic test_backpressure();
    int lat;
    send_word(16'h4000, 1'b1, lat);
    in_valid = 1'b1;
    word_in  = 16'hFFFF;
    in_first = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (word_out !== 16'h5555 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold cyc %0d got word=%h ready=%b valid=%b want 5555/0/1",
                 c, word_out, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got ready=%b valid=%b want 1/0", in_ready, out_valid);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept got ready=%b want 0", in_ready);
    end
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != N || word_out !== 16'hE4E4) begin
      errors++;
      $display("FAIL bp_second_word got %h lat %0d want e4e4 lat %0d", word_out, lat, N);
    end
    take_out();
  endtask

  task automatic test_reset_mid();
    int lat;
    send_word(16'h4000, 1'b1, lat);
    take_out();
    @(negedge clk);
    in_valid = 1'b1;
    word_in  = 16'h0000;
    in_first = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || word_out !== 16'h0000 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b word=%h ready=%b want 0/0000/0",
               out_valid, word_out, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    send_word(16'h4000, 1'b0, lat);
    checks++;
    if (word_out !== 16'h5555 || lat != N) begin
      errors++;
      $display("FAIL reset_carry got %h lat %0d want 5555 lat %0d", word_out, lat, N);
    end
    take_out();
  endtask

  task automatic test_n1();
    int lat;
    logic [1:0] exp_w;
    logic [1:0] words [2];
    logic       firsts [2];
`ifdef DIFF_DEC_CHAIN_EN
    exp_w = 2'b00;
`else
    exp_w = 2'b11;
`endif
    words[0] = 2'b01;
    firsts[0] = 1'b1;
    words[1] = 2'b11;
    firsts[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_valid1 = 1'b1;
      word_in1  = words[k];
      in_first1 = firsts[k];
      @(posedge clk);
      @(negedge clk);
      in_valid1 = 1'b0;
      lat = 0;
      while (out_valid1 !== 1'b1 && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != 1 || word_out1 !== ((k == 0) ? 2'b01 : exp_w)) begin
        errors++;
        $display("FAIL n1_word%0d got %b lat %0d want %b lat 1", k, word_out1, lat,
                 (k == 0) ? 2'b01 : exp_w);
      end
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_first   = 1'b0;
    word_in    = '0;
    out_ready  = 1'b0;
    in_valid1  = 1'b0;
    in_first1  = 1'b0;
    word_in1   = '0;
    out_ready1 = 1'b0;
    test_reset();
    test_decode();
    test_wrap();
    test_chain();
    test_backpressure();
    test_reset_mid();
    test_n1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
